// File: rtl/mult_rr_scheduler_if.sv
// Signal bundle between the round-robin multiply scheduler, its requesters and the
// shared sequential multiply unit. The slave modport is the scheduler's view.
interface mult_rr_scheduler_if #(
  parameter int IDW   = 2,
  parameter int WIDTH = 32
);
  localparam int NREQ = 2 ** IDW;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_mcand;
  logic [NREQ*WIDTH-1:0] req_mplier;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [2*WIDTH-1:0]    rsp_prod;
  logic                  rsp_err;

  logic                  mul_reset;
  logic [WIDTH-1:0]      mul_mcand;
  logic [WIDTH-1:0]      mul_mplier;
  logic                  mul_fin;
  logic [2*WIDTH-1:0]    mul_prod;

  modport slave (
    input  req_valid, req_mcand, req_mplier, rsp_ready, mul_fin, mul_prod,
    output req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err,
           mul_reset, mul_mcand, mul_mplier
  );

  modport master (
    output req_valid, req_mcand, req_mplier, rsp_ready, mul_fin, mul_prod,
    input  req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err,
           mul_reset, mul_mcand, mul_mplier
  );
endinterface

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one sequential multiply unit among 2**IDW requesters:
// grants one job, pulses the unit's start reset, waits for fin (or times out), returns the product.
module mult_rr_scheduler #(
  parameter int IDW     = 2,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  mult_rr_scheduler_if.slave bus,
  output logic               busy,
  output logic               err_timeout
);
  localparam int NREQ  = 2 ** IDW;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       ptr_q;
  logic [IDW-1:0]       id_q;
  logic [WIDTH-1:0]     mcand_q, mplier_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic                 err_q;
  logic                 err_timeout_q;
  logic [CNT_W-1:0]     cnt_q;

  logic                 grant_any;
  logic [IDW-1:0]       grant_id;
  logic [IDW-1:0]       idx;
  logic                 run_done;

  // Search starts one past the last winner, so each waiting requester is
  // served within NREQ-1 jobs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = ptr_q + IDW'(off);
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
  end

  assign run_done = bus.mul_fin || (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any)     state_d = START;
      START:                      state_d = RUN;
      RUN:     if (run_done)      state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    bus.mul_reset = 1'b0;
    bus.rsp_valid = 1'b0;
    busy          = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (grant_any) bus.req_ready[grant_id] = 1'b1;
      end
      START:   bus.mul_reset = 1'b1;
      RESP:    bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Job datapath: operands and id latched at grant, result captured at end of RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q         <= IDW'(NREQ - 1);
      id_q          <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      prod_q        <= '0;
      err_q         <= 1'b0;
      err_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            mcand_q  <= bus.req_mcand[grant_id*WIDTH +: WIDTH];
            mplier_q <= bus.req_mplier[grant_id*WIDTH +: WIDTH];
            id_q     <= grant_id;
            ptr_q    <= grant_id;
          end
        end
        START: cnt_q <= '0;
        RUN: begin
          if (bus.mul_fin) begin
            prod_q <= bus.mul_prod;
            err_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            prod_q        <= '0;
            err_q         <= 1'b1;
            err_timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mul_mcand  = mcand_q;
  assign bus.mul_mplier = mplier_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_prod   = prod_q;
  assign bus.rsp_err    = err_q;
  assign err_timeout    = err_timeout_q;
endmodule
